// File: rtl/prefetch_issue_queue_if.sv
// rtl/prefetch_issue_queue_if.sv - demand/prefetch inputs and memory-issue outputs of the prefetch issue queue
interface prefetch_issue_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              memAccess;
  logic [ADDR_W-1:0] memAddress;
  logic              memRequest;
  logic [ADDR_W-1:0] requestAddress;
  logic              issueValid;
  logic [ADDR_W-1:0] issueAddr;
  logic              issuePrefetch;
  logic              pfDropped;
  logic              demandOverrun;
  logic [CNT_W-1:0]  queueCount;

  modport master (
    output memAccess, memAddress, memRequest, requestAddress,
    input  issueValid, issueAddr, issuePrefetch, pfDropped, demandOverrun, queueCount
  );

  modport slave (
    input  memAccess, memAddress, memRequest, requestAddress,
    output issueValid, issueAddr, issuePrefetch, pfDropped, demandOverrun, queueCount
  );
endinterface

// File: rtl/prefetch_issue_queue.sv
// rtl/prefetch_issue_queue.sv - prefetch FIFO merged with demand accesses onto one memory port
// Optional macro PF_STATS_EN adds saturating pfIssuedCnt/pfDroppedCnt outputs.
module prefetch_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  prefetch_issue_queue_if.slave bus
`ifdef PF_STATS_EN
  ,
  output logic [15:0]           pfIssuedCnt,
  output logic [15:0]           pfDroppedCnt
`endif
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     busy_cnt, busy_cnt_nxt;
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DEPTH-1:0]  fifo_vld, vld_nxt, sq_mask;
  logic [PW-1:0]     head, tail, vld_count;
  logic [IW-1:0]     head_idx, tail_idx;
  logic              d_pend;
  logic [ADDR_W-1:0] d_addr, cand_addr;
  logic              empty, full, head_ok, skip, idle;
  logic              issue_d, issue_a, issue_f, issue, pop, push, drop, pf_hit;

  assign head_idx       = head[IW-1:0];
  assign tail_idx       = tail[IW-1:0];
  assign bus.queueCount = vld_count;

  always_comb begin
    empty   = (head == tail);
    full    = (head_idx == tail_idx) && (head[PW-1] != tail[PW-1]);
    head_ok = !empty && fifo_vld[head_idx];
    skip    = !empty && !fifo_vld[head_idx];
    idle    = (state == IDLE);
    issue_d = idle && d_pend;
    issue_a = idle && !d_pend && bus.memAccess;
    issue_f = idle && !d_pend && !bus.memAccess && head_ok;
    issue   = issue_d || issue_a || issue_f;
    // Squashed entries are retired from the head one per cycle without issuing.
    pop     = issue_f || skip;

    pf_hit    = 1'b0;
    sq_mask   = '0;
    vld_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && fifo_addr[i] == bus.requestAddress) pf_hit = 1'b1;
      if (fifo_vld[i] && fifo_addr[i] == bus.memAddress) sq_mask[i] = bus.memAccess;
      vld_count = vld_count + PW'(fifo_vld[i]);
    end

    drop = bus.memRequest && (pf_hit
                              || (d_pend && d_addr == bus.requestAddress)
                              || (bus.memAccess && bus.memAddress == bus.requestAddress)
                              || (full && !pop));
    push = bus.memRequest && !drop;

    // Push is applied last so a full queue popping and pushing the same slot keeps the new entry.
    vld_nxt = fifo_vld & ~sq_mask;
    if (pop)  vld_nxt[head_idx] = 1'b0;
    if (push) vld_nxt[tail_idx] = 1'b1;

    cand_addr = issue_d ? d_addr : (issue_a ? bus.memAddress : fifo_addr[head_idx]);

    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    case (state)
      IDLE: if (issue && MEM_LAT > 1) begin
        state_nxt    = BUSY;
        busy_cnt_nxt = CW'(MEM_LAT - 1);
      end
      BUSY: if (busy_cnt == CW'(1)) state_nxt = IDLE;
            else busy_cnt_nxt = busy_cnt - CW'(1);
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_cnt <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_addr[tail_idx] <= bus.requestAddress;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head              <= '0;
      tail              <= '0;
      fifo_vld          <= '0;
      d_pend            <= 1'b0;
      d_addr            <= '0;
      bus.issueValid    <= 1'b0;
      bus.issueAddr     <= '0;
      bus.issuePrefetch <= 1'b0;
      bus.pfDropped     <= 1'b0;
      bus.demandOverrun <= 1'b0;
    end else begin
      fifo_vld <= vld_nxt;
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);

      if (bus.memAccess && !issue_a) begin
        d_pend <= 1'b1;
        d_addr <= bus.memAddress;
      end else if (issue_d) begin
        d_pend <= 1'b0;
      end
      bus.demandOverrun <= bus.memAccess && d_pend && !issue_d;

      bus.issueValid <= issue;
      if (issue) begin
        bus.issueAddr     <= cand_addr;
        bus.issuePrefetch <= issue_f;
      end
      bus.pfDropped <= drop;
    end
  end

`ifdef PF_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pfIssuedCnt  <= '0;
      pfDroppedCnt <= '0;
    end else begin
      if (issue_f && pfIssuedCnt != 16'hFFFF)  pfIssuedCnt  <= pfIssuedCnt + 16'd1;
      if (drop && pfDroppedCnt != 16'hFFFF)    pfDroppedCnt <= pfDroppedCnt + 16'd1;
    end
  end
`endif
endmodule
